// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
// Shares one W-bit bank of level-sensitive D latches between N requesters.
// Write requests are arbitrated round-robin. Each write drives the data first,
// opens the enable for OPEN_CYCLES cycles, then closes it while the data is
// still held, and finally pulses done to the winning requester.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_rst      synchronous active-high reset
//   i_req      [N]   per-requester write request (level, held until done)
//   i_wdata    [N*W] requester data, requester i at [i*W +: W]
//   o_grant    [N]   one-hot owner of the current write, 0 when idle
//   o_done     [N]   one-cycle completion pulse to the owner
//   o_latch_d  [W]   data to the latch bank d inputs
//   o_latch_en        latch bank enable
//   o_busy            high whenever the FSM is not idle
//
// state  | meaning
// IDLE   | arbitrate; sample req/wdata, register grant and latch_d
// SETUP  | data stable on latch_d, enable still low
// OPEN   | enable high for OPEN_CYCLES cycles
// HOLD   | enable low, data still held
// DONE   | done pulse to owner, grant cleared
module latch_write_arbiter #(
  parameter int N           = 4,
  parameter int W           = 8,
  parameter int OPEN_CYCLES = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_wdata,
  output logic [N-1:0]   o_grant,
  output logic [N-1:0]   o_done,
  output logic [W-1:0]   o_latch_d,
  output logic           o_latch_en,
  output logic           o_busy
);

  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(OPEN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_OPEN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CNTW-1:0] r_open_cnt;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] w_win;
  logic [IDXW-1:0] w_cand;
  logic            w_found;
  logic [W-1:0]    w_wdata_arr [N];

  logic [N-1:0]    r_grant;
  logic [N-1:0]    r_done;
  logic [W-1:0]    r_latch_d;
  logic            r_latch_en;
  logic            r_busy;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_wdata_arr[i] = i_wdata[i*W +: W];
    end
  end

  // Round-robin search starting at r_ptr, wrapping; first set request wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_cand = IDXW'((int'(r_ptr) + k) % N);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_SETUP;
      S_SETUP: w_state_nxt = S_OPEN;
      S_OPEN:  if (r_open_cnt == CNTW'(1)) w_state_nxt = S_HOLD;
      S_HOLD:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with
  // the state it belongs to without any input-to-output path.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_open_cnt <= '0;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_done     <= '0;
      r_latch_d  <= '0;
      r_latch_en <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_latch_en <= (w_state_nxt == S_OPEN);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE) ? r_grant : '0;

      if (r_state == S_IDLE && w_found) begin
        r_grant   <= N'(1) << w_win;
        r_latch_d <= w_wdata_arr[w_win];
        r_ptr     <= (w_win == IDXW'(N - 1)) ? '0 : w_win + 1'b1;
      end else if (w_state_nxt == S_DONE) begin
        r_grant   <= '0;
      end

      if (r_state == S_SETUP) begin
        r_open_cnt <= CNTW'(OPEN_CYCLES);
      end else if (r_state == S_OPEN) begin
        r_open_cnt <= r_open_cnt - 1'b1;
      end
    end
  end

  assign o_grant    = r_grant;
  assign o_done     = r_done;
  assign o_latch_d  = r_latch_d;
  assign o_latch_en = r_latch_en;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_latch_write_arbiter.sv
module tb_latch_write_arbiter;

  logic        clk;
  logic        rst, rst1;
  logic [3:0]  req, req1;
  logic [31:0] wdata, wdata1;
  logic [3:0]  grant, done, grant1, done1;
  logic [7:0]  latch_d, latch_d1;
  logic        latch_en, latch_en1, busy, busy1;
  logic [7:0]  q, q1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] exp_grant, exp_done;
  logic [7:0] exp_d;
  logic       exp_en, exp_busy;

  latch_write_arbiter #(.N(4), .W(8), .OPEN_CYCLES(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_wdata(wdata),
    .o_grant(grant), .o_done(done), .o_latch_d(latch_d),
    .o_latch_en(latch_en), .o_busy(busy)
  );

  latch_write_arbiter #(.N(4), .W(8), .OPEN_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst(rst1), .i_req(req1), .i_wdata(wdata1),
    .o_grant(grant1), .o_done(done1), .o_latch_d(latch_d1),
    .o_latch_en(latch_en1), .o_busy(busy1)
  );

  // Behavioural latch banks fed by the arbiters.
  always_latch begin
    if (latch_en) q <= latch_d;
  end
  always_latch begin
    if (latch_en1) q1 <= latch_d1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rst1 = 1'b1;
    tick(); tick();
    n_tests++; if (grant !== 4'b0) begin n_fail++; $display("FAIL reset_grant got %b exp 0000", grant); end
    n_tests++; if (done !== 4'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0000", done); end
    n_tests++; if (latch_d !== 8'h00) begin n_fail++; $display("FAIL reset_latch_d got %h exp 00", latch_d); end
    n_tests++; if (latch_en !== 1'b0) begin n_fail++; $display("FAIL reset_latch_en got %b exp 0", latch_en); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (busy1 !== 1'b0 || latch_en1 !== 1'b0) begin n_fail++; $display("FAIL reset_dut1 got busy=%b en=%b exp 0 0", busy1, latch_en1); end
    rst = 1'b0; rst1 = 1'b0;
  endtask

  // req=0100, wdata[2]=A5: SETUP k1, OPEN k2-3, HOLD k4, DONE k5, IDLE k6.
  task automatic test_single();
    wdata = 32'h0;
    wdata[23:16] = 8'hA5;
    req = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_grant = (k <= 4) ? 4'b0100 : 4'b0000;
      exp_en    = (k == 2 || k == 3);
      exp_done  = (k == 5) ? 4'b0100 : 4'b0000;
      exp_busy  = (k <= 5);
      n_tests++; if (grant !== exp_grant) begin n_fail++; $display("FAIL single_grant k=%0d got %b exp %b", k, grant, exp_grant); end
      n_tests++; if (latch_en !== exp_en) begin n_fail++; $display("FAIL single_en k=%0d got %b exp %b", k, latch_en, exp_en); end
      n_tests++; if (done !== exp_done) begin n_fail++; $display("FAIL single_done k=%0d got %b exp %b", k, done, exp_done); end
      n_tests++; if (busy !== exp_busy) begin n_fail++; $display("FAIL single_busy k=%0d got %b exp %b", k, busy, exp_busy); end
      n_tests++; if (latch_d !== 8'hA5) begin n_fail++; $display("FAIL single_latch_d k=%0d got %h exp a5", k, latch_d); end
      if (k == 5) req = 4'b0000;
    end
    n_tests++; if (q !== 8'hA5) begin n_fail++; $display("FAIL single_q got %h exp a5", q); end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wdata = 32'h43322110;
    req = 4'b1111;
    for (int w = 0; w < 5; w++) begin
      for (int k = 1; k <= 6; k++) begin
        tick();
        exp_grant = (k <= 4) ? (4'b0001 << (w % 4)) : 4'b0000;
        exp_done  = (k == 5) ? (4'b0001 << (w % 4)) : 4'b0000;
        exp_d     = 8'((w % 4) * 8'h11 + 8'h10);
        n_tests++; if (grant !== exp_grant) begin n_fail++; $display("FAIL rr_grant w=%0d k=%0d got %b exp %b", w, k, grant, exp_grant); end
        n_tests++; if (done !== exp_done) begin n_fail++; $display("FAIL rr_done w=%0d k=%0d got %b exp %b", w, k, done, exp_done); end
        n_tests++; if ($countones(grant) > 1) begin n_fail++; $display("FAIL rr_onehot w=%0d k=%0d got %b exp at most one bit", w, k, grant); end
        if (k == 1) begin
          n_tests++; if (latch_d !== exp_d) begin n_fail++; $display("FAIL rr_latch_d w=%0d got %h exp %h", w, latch_d, exp_d); end
        end
        if (k == 5) begin
          n_tests++; if (q !== exp_d) begin n_fail++; $display("FAIL rr_q w=%0d got %h exp %h", w, q, exp_d); end
        end
        if (w == 4 && k == 5) req = 4'b0000;
      end
    end
  endtask

  task automatic test_stability();
    wdata[15:8] = 8'h3C;
    req = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_done = (k == 5) ? 4'b0010 : 4'b0000;
      n_tests++; if (latch_d !== 8'h3C) begin n_fail++; $display("FAIL stab_latch_d k=%0d got %h exp 3c", k, latch_d); end
      n_tests++; if (done !== exp_done) begin n_fail++; $display("FAIL stab_done k=%0d got %b exp %b", k, done, exp_done); end
      wdata[15:8] = 8'(k * 8'h11);
      if (k == 5) begin
        req = 4'b0000;
        n_tests++; if (q !== 8'h3C) begin n_fail++; $display("FAIL stab_q got %h exp 3c", q); end
      end
    end
  endtask

  task automatic test_drop();
    wdata[31:24] = 8'hC3;
    req = 4'b1000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL drop_grant got %b exp 1000", grant); end
      end
      if (k == 2) req = 4'b0000;
      exp_done = (k == 5) ? 4'b1000 : 4'b0000;
      n_tests++; if (done !== exp_done) begin n_fail++; $display("FAIL drop_done k=%0d got %b exp %b", k, done, exp_done); end
    end
    n_tests++; if (q !== 8'hC3) begin n_fail++; $display("FAIL drop_q got %h exp c3", q); end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_tests++; if (grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_regrant k=%0d got grant=%b busy=%b exp 0000 0", k, grant, busy); end
    end
  endtask

  task automatic test_reset_mid();
    wdata[23:16] = 8'h5A;
    req = 4'b0100;
    tick();
    tick();
    n_tests++; if (latch_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_open got %b exp 1", latch_en); end
    rst = 1'b1;
    tick();
    n_tests++; if (latch_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_en got %b exp 0", latch_en); end
    n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rstmid_grant got %b exp 0000", grant); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    n_tests++; if (latch_d !== 8'h00) begin n_fail++; $display("FAIL rstmid_latch_d got %h exp 00", latch_d); end
    n_tests++; if (done !== 4'b0000) begin n_fail++; $display("FAIL rstmid_done got %b exp 0000", done); end
    rst = 1'b0;
    wdata[15:8] = 8'h77;
    req = 4'b1010;
    tick();
    n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rstmid_first got %b exp 0010", grant); end
    n_tests++; if (latch_d !== 8'h77) begin n_fail++; $display("FAIL rstmid_first_d got %h exp 77", latch_d); end
    for (int k = 2; k <= 5; k++) begin
      tick();
      exp_done = (k == 5) ? 4'b0010 : 4'b0000;
      n_tests++; if (done !== exp_done) begin n_fail++; $display("FAIL rstmid_done2 k=%0d got %b exp %b", k, done, exp_done); end
      if (k == 5) req = 4'b0000;
    end
    tick();
  endtask

  // OPEN_CYCLES=1: SETUP k1, OPEN k2, HOLD k3, DONE k4, IDLE k5.
  task automatic test_open1();
    wdata1 = 32'h0;
    wdata1[7:0] = 8'hE7;
    req1 = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_en   = (k == 2);
      exp_done = (k == 4) ? 4'b0001 : 4'b0000;
      exp_busy = (k <= 4);
      n_tests++; if (latch_en1 !== exp_en) begin n_fail++; $display("FAIL open1_en k=%0d got %b exp %b", k, latch_en1, exp_en); end
      n_tests++; if (done1 !== exp_done) begin n_fail++; $display("FAIL open1_done k=%0d got %b exp %b", k, done1, exp_done); end
      n_tests++; if (busy1 !== exp_busy) begin n_fail++; $display("FAIL open1_busy k=%0d got %b exp %b", k, busy1, exp_busy); end
      if (k == 4) req1 = 4'b0000;
    end
    n_tests++; if (q1 !== 8'hE7) begin n_fail++; $display("FAIL open1_q got %h exp e7", q1); end
  endtask

  initial begin
    rst = 1'b1; rst1 = 1'b1;
    req = 4'b0; req1 = 4'b0;
    wdata = 32'h0; wdata1 = 32'h0;
    test_reset();
    test_single();
    test_contention();
    test_stability();
    test_drop();
    test_reset_mid();
    test_open1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/latch_write_arbiter.md
# latch_write_arbiter

Sequencing controller that shares one W-bit level-sensitive D-latch bank between N requesters. It arbitrates write requests round-robin and drives the latch data bus. It generates a clean enable window around the data: data is set up first, then the enable is held open, then closed with data still held. It signals completion to the winning requester. It sits between requester logic and the `d`/`en` inputs of a bank of gated D latches.

## Interface
Parameters:
- N, 4, number of requesters (≥2)
- W, 8, latch data width
- OPEN_CYCLES, 2, cycles latch_en is held high per write (≥1)

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- req  input  N  per-requester write request, level; held until matching done bit
- wdata  input  N*W  requester data, requester i at bits [i*W +: W]
- grant  output  N  one-hot owner of current write, 0 when idle
- done  output  N  one-cycle completion pulse to the owner
- latch_d  output  W  data to latch bank `d`
- latch_en  output  1  latch bank `en`
- busy  output  1  high whenever state ≠ IDLE

## Operation
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE → SETUP → OPEN → HOLD → DONE → IDLE.
- IDLE: if any req bit is set, pick the winner by round-robin, then register grant and latch_d = wdata[winner], and go to SETUP. Otherwise stay in IDLE.
- SETUP: 1 cycle, latch_en=0, latch_d stable.
- OPEN: latch_en=1 for exactly OPEN_CYCLES cycles, tracked by a counter of width clog2(OPEN_CYCLES+1).
- HOLD: 1 cycle, latch_en=0, latch_d unchanged. This guarantees hold time on the falling enable.
- DONE: done[winner]=1 for this cycle only. grant clears on entry to DONE. latch_d retains its value; the next state is IDLE.
- Round-robin rule: search starts at (last winner + 1) mod N and wraps. After reset, the pointer makes requester 0 highest priority.
- wdata and req are sampled only in IDLE. Changes to them during a transaction are ignored, and dropping req mid-transaction does not abort the write.
- busy = (state ≠ IDLE).
- latch_d and grant change only on the IDLE→SETUP transition (grant also clears at DONE). latch_d never changes while latch_en=1 or in the cycle around it.

## Timing
- Reset values: state IDLE, grant=0, done=0, latch_d=0, latch_en=0, busy=0, round-robin pointer so that req[0] wins first.
- Request seen in IDLE at cycle t produces:
  - grant and latch_d valid and busy=1 at t+1 (SETUP)
  - latch_en=1 for cycles t+2 … t+1+OPEN_CYCLES
  - latch_en=0 at t+2+OPEN_CYCLES (HOLD)
  - done pulse at t+3+OPEN_CYCLES
  - IDLE at t+4+OPEN_CYCLES
- Each write occupies OPEN_CYCLES+4 cycles, including the IDLE arbitration cycle. The next grant is decided in that IDLE cycle at the earliest.
- Simultaneous requests: exactly one winner per IDLE cycle. The others wait and are served in rotation order, so no requester waits more than N-1 writes.
- A requester that still holds req in the IDLE cycle right after its own done is treated as a new request. It has the lowest priority in that arbitration.
- Reset mid-operation: on the next edge all outputs take their reset values. latch_en falls without a HOLD cycle, and no done is issued. The latch contents are outside the block's control and are undefined.
- rst has priority over all other inputs.

## Test plan
- Single write: N=4, W=8, OPEN_CYCLES=2, req=4'b0100, wdata[2]=8'hA5 → at t+1 grant=4'b0100 and latch_d=8'hA5; latch_en=1 at t+2 and t+3 only; done=4'b0100 at t+5 only; back in IDLE at t+6. The latch model q reads 8'hA5 afterward.
- Contention: req=4'b1111 held continuously → grants in order 0,1,2,3,0, one every 6 cycles. Each done pulse goes to the matching bit and no two grant bits are ever set at once.
- Data stability: change wdata[1] every cycle during requester 1's write → latch_d stays at the IDLE-sampled value from SETUP through DONE, and the latch model captures the sampled value.
- Request drop: deassert req[3] during OPEN → the write completes normally, done[3] fires, and requester 3 is not re-granted afterward.
- Reset mid-write: assert rst during the first OPEN cycle → the next edge gives latch_en=0, grant=0, busy=0, and latch_d=0, with no done. With req=4'b1010 after rst drops, requester 1 is granted first.
- OPEN_CYCLES=1 build: single request → latch_en high for exactly one cycle, and done at t+4.
